// File: rtl/move_player.sv
`default_nettype none
// move_player: replays the solver's packed 2-bit move list into the board datapath,
// either auto-played at a fixed tick rate or single-stepped by push button.
module move_player #(
    parameter  int TICK_W     = 12,
    parameter  int STEP_TICKS = 256,
    parameter  int MAX_MOVES  = 32,
    localparam int IDX_W      = $clog2(MAX_MOVES),
    localparam int CNT_W      = $clog2(MAX_MOVES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comp,
    input  logic [CNT_W-1:0]       cnt,
    input  logic [2*MAX_MOVES-1:0] ord,
    input  logic                   btn_play,
    input  logic                   btn_step,
    input  logic                   btn_rew,
    input  logic                   mv_ready,
    output logic                   mv_valid,
    output logic [1:0]             mv_dir,
    output logic [IDX_W-1:0]       mv_idx,
    output logic [IDX_W-1:0]       num,
    output logic                   playing,
    output logic                   done,
    output logic                   rew_pulse
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PAUSE = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0]      STEP_LAST = 16'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] CE_MAX    = CNT_W'(MAX_MOVES);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  presc_q;
    logic [15:0]        step_q, step_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [2:0]         flag_q, flag_d;
    logic               playing_q, playing_d;
    logic               rew_pend_q, rew_pend_d;
    logic               mv_valid_q, mv_valid_d;
    logic [1:0]         mv_dir_q, mv_dir_d;
    logic [IDX_W-1:0]   mv_idx_q, mv_idx_d;
    logic               rew_pulse_q, rew_pulse_d;
    logic               go_issue;

    logic               tick;
    logic [2:0]         btn_vec;
    logic [2:0]         edge_raw;
    logic               e_rew, e_play, e_step;
    logic [CNT_W-1:0]   ce;
    logic [CNT_W-1:0]   num_inc;
    logic               hs;
    logic [1:0]         cur_dir;

    assign tick     = &presc_q;
    assign btn_vec  = {btn_rew, btn_play, btn_step};
    assign edge_raw = {3{tick}} & btn_vec & ~flag_q;
    // Flags track every button even when a higher-priority edge wins the tick.
    assign flag_d   = tick ? btn_vec : flag_q;
    assign e_rew    = edge_raw[2];
    assign e_play   = edge_raw[1] & ~edge_raw[2];
    assign e_step   = edge_raw[0] & ~(|edge_raw[2:1]);
    assign ce       = (cnt > CE_MAX) ? CE_MAX : cnt;
    assign num_inc  = num_q + 1'b1;
    assign hs       = mv_valid_q & mv_ready;
    assign cur_dir  = ord[2*num_q[IDX_W-1:0] +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            num_q       <= '0;
            flag_q      <= '0;
            playing_q   <= 1'b0;
            rew_pend_q  <= 1'b0;
            mv_valid_q  <= 1'b0;
            mv_dir_q    <= '0;
            mv_idx_q    <= '0;
            rew_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            num_q       <= num_d;
            flag_q      <= flag_d;
            playing_q   <= playing_d;
            rew_pend_q  <= rew_pend_d;
            mv_valid_q  <= mv_valid_d;
            mv_dir_q    <= mv_dir_d;
            mv_idx_q    <= mv_idx_d;
            rew_pulse_q <= rew_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        num_d       = num_q;
        playing_d   = playing_q;
        rew_pend_d  = rew_pend_q;
        mv_valid_d  = mv_valid_q;
        mv_dir_d    = mv_dir_q;
        mv_idx_d    = mv_idx_q;
        rew_pulse_d = 1'b0;
        go_issue    = 1'b0;

        if (!comp) begin
            state_d    = S_IDLE;
            step_d     = '0;
            num_d      = '0;
            playing_d  = 1'b0;
            rew_pend_d = 1'b0;
            mv_valid_d = 1'b0;
            mv_dir_d   = '0;
            mv_idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = (ce == '0) ? S_DONE : S_PAUSE;
                end
                S_PAUSE: begin
                    if (e_rew) begin
                        num_d       = '0;
                        rew_pulse_d = 1'b1;
                    end else if (e_play) begin
                        state_d   = S_WAIT;
                        playing_d = 1'b1;
                        step_d    = '0;
                    end else if (e_step) begin
                        go_issue = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (e_rew) begin
                        state_d     = S_PAUSE;
                        playing_d   = 1'b0;
                        num_d       = '0;
                        step_d      = '0;
                        rew_pulse_d = 1'b1;
                    end else if (e_play) begin
                        state_d   = S_PAUSE;
                        playing_d = 1'b0;
                        step_d    = '0;
                    end else if (tick) begin
                        if (step_q == STEP_LAST) begin
                            go_issue = 1'b1;
                        end else begin
                            step_d = step_q + 16'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (e_rew) begin
                        rew_pend_d = 1'b1;
                    end
                    if (e_play) begin
                        playing_d = ~playing_q;
                    end
                    if (hs) begin
                        mv_valid_d = 1'b0;
                        rew_pend_d = 1'b0;
                        if (rew_pend_q || e_rew) begin
                            state_d     = S_PAUSE;
                            num_d       = '0;
                            playing_d   = 1'b0;
                            rew_pulse_d = 1'b1;
                        end else begin
                            num_d = num_inc;
                            if (num_inc == ce) begin
                                state_d   = S_DONE;
                                playing_d = 1'b0;
                            end else if (playing_d) begin
                                state_d = S_WAIT;
                                step_d  = '0;
                            end else begin
                                state_d = S_PAUSE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // An empty list has nothing to replay, so a rewind stays in DONE.
                    if (e_rew) begin
                        num_d       = '0;
                        rew_pulse_d = 1'b1;
                        state_d     = (ce == '0) ? S_DONE : S_PAUSE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (go_issue) begin
            state_d    = S_ISSUE;
            step_d     = '0;
            mv_valid_d = 1'b1;
            mv_dir_d   = cur_dir;
            mv_idx_d   = num_q[IDX_W-1:0];
        end
    end

    assign mv_valid  = mv_valid_q;
    assign mv_dir    = mv_dir_q;
    assign mv_idx    = mv_idx_q;
    // Display index wraps to 0 only when a full MAX_MOVES list completes.
    assign num       = num_q[IDX_W-1:0];
    assign playing   = playing_q;
    assign done      = (state_q == S_DONE);
    assign rew_pulse = rew_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_move_player.sv
`default_nettype none
// Directed bench for move_player: fast prescaler (tick every 4 clocks), STEP_TICKS=4.
module tb_move_player;

    localparam int TICK_W     = 2;
    localparam int STEP_TICKS = 4;
    localparam int MAX_MOVES  = 32;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        comp     = 1'b0;
    logic [5:0]  cnt      = '0;
    logic [63:0] ord      = '0;
    logic        btn_play = 1'b0;
    logic        btn_step = 1'b0;
    logic        btn_rew  = 1'b0;
    logic        mv_ready = 1'b0;
    logic        mv_valid;
    logic [1:0]  mv_dir;
    logic [4:0]  mv_idx;
    logic [4:0]  num;
    logic        playing;
    logic        done;
    logic        rew_pulse;
    logic [15:0] outs;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hs_n        = 0;
    int rew_cnt     = 0;
    int rc;
    logic stable;
    logic pulse_seen;
    logic [1:0] hs_dir [0:63];
    logic [4:0] hs_idx [0:63];
    int         hs_t   [0:63];

    move_player #(
        .TICK_W    (TICK_W),
        .STEP_TICKS(STEP_TICKS),
        .MAX_MOVES (MAX_MOVES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .comp     (comp),
        .cnt      (cnt),
        .ord      (ord),
        .btn_play (btn_play),
        .btn_step (btn_step),
        .btn_rew  (btn_rew),
        .mv_ready (mv_ready),
        .mv_valid (mv_valid),
        .mv_dir   (mv_dir),
        .mv_idx   (mv_idx),
        .num      (num),
        .playing  (playing),
        .done     (done),
        .rew_pulse(rew_pulse)
    );

    assign outs = {mv_valid, mv_dir, mv_idx, num, playing, done, rew_pulse};

    always #5 clk = ~clk;

    // Handshake log and rewind-pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mv_valid && mv_ready && hs_n < 64) begin
            hs_dir[hs_n] <= mv_dir;
            hs_idx[hs_n] <= mv_idx;
            hs_t[hs_n]   <= cyc;
            hs_n         <= hs_n + 1;
        end
        if (rew_pulse) rew_cnt <= rew_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {rew, play, step}; two ticks high then two ticks low.
    task automatic press(input logic [2:0] m);
        btn_rew  = m[2];
        btn_play = m[1];
        btn_step = m[0];
        wait_cyc(8);
        btn_rew  = 1'b0;
        btn_play = 1'b0;
        btn_step = 1'b0;
        wait_cyc(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        wait_cyc(3);
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        comp = 1'b1; cnt = 6'd3; ord = 64'h39; mv_ready = 1'b1;
        wait_cyc(2);
        chk("pause_outs", outs, 0);

        // Single-step through 3 moves
        press(3'b001);
        chk("s1_count", hs_n, 1);
        chk("s1_dir", hs_dir[0], 1);
        chk("s1_idx", hs_idx[0], 0);
        chk("s1_num", num, 1);
        press(3'b001);
        chk("s2_dir", hs_dir[1], 2);
        chk("s2_idx", hs_idx[1], 1);
        press(3'b001);
        chk("s3_dir", hs_dir[2], 3);
        chk("s3_idx", hs_idx[2], 2);
        chk("s3_num", num, 3);
        chk("s3_done", done, 1);
        press(3'b001);
        chk("s4_no_move", hs_n, 3);
        chk("s4_valid", mv_valid, 0);
        chk("s4_done", done, 1);

        // Abort to IDLE, then auto-play over 5 moves
        comp = 1'b0;
        wait_cyc(1);
        chk("idle_outs", {num, done, playing}, 0);
        cnt = 6'd5; ord = 64'hE4; comp = 1'b1;
        wait_cyc(2);
        press(3'b010);
        chk("auto_playing", playing, 1);
        for (int i = 0; i < 300 && hs_n < 5; i++) wait_cyc(1);
        btn_play = 1'b1;
        chk("auto_two_moves", hs_n, 5);
        wait_cyc(8);
        btn_play = 1'b0;
        wait_cyc(8);
        chk("auto_dir0", hs_dir[3], 0);
        chk("auto_dir1", hs_dir[4], 1);
        chk("auto_idx1", hs_idx[4], 1);
        chk("auto_spacing", hs_t[4] - hs_t[3], 16);
        chk("pause_playing", playing, 0);
        chk("pause_num", num, 2);
        wait_cyc(80);
        chk("pause_no_move", hs_n, 5);

        // Back-pressure with rewind pending
        mv_ready = 1'b0;
        btn_step = 1'b1;
        for (int i = 0; i < 20 && !mv_valid; i++) wait_cyc(1);
        btn_step = 1'b0;
        chk("bp_valid", mv_valid, 1);
        chk("bp_dir", mv_dir, 2);
        chk("bp_idx", mv_idx, 2);
        stable = 1'b1;
        pulse_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) btn_rew = 1'b1;
            if (i == 18) btn_rew = 1'b0;
            wait_cyc(1);
            if (!(mv_valid === 1'b1 && mv_dir === 2'd2 && mv_idx === 5'd2)) stable = 1'b0;
            if (rew_pulse !== 1'b0) pulse_seen = 1'b1;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_early_pulse", pulse_seen, 0);
        rc = rew_cnt;
        mv_ready = 1'b1;
        wait_cyc(1);
        chk("bp_rew_pulse", rew_pulse, 1);
        chk("bp_valid_drop", mv_valid, 0);
        chk("bp_num", num, 0);
        chk("bp_hs", hs_n, 6);
        chk("bp_hs_dir", hs_dir[5], 2);
        wait_cyc(1);
        chk("bp_pulse_end", rew_pulse, 0);
        chk("bp_pulse_count", rew_cnt - rc, 1);
        chk("bp_playing", playing, 0);

        // Play and rewind on the same tick
        press(3'b001);
        press(3'b001);
        chk("pr_dir0", hs_dir[6], 0);
        chk("pr_dir1", hs_dir[7], 1);
        chk("pr_num2", num, 2);
        rc = rew_cnt;
        press(3'b110);
        chk("pr_num", num, 0);
        chk("pr_playing", playing, 0);
        chk("pr_pulses", rew_cnt - rc, 1);
        wait_cyc(40);
        chk("pr_no_move", hs_n, 8);

        // comp drop during stalled ISSUE, then empty list
        mv_ready = 1'b0;
        btn_step = 1'b1;
        for (int i = 0; i < 20 && !mv_valid; i++) wait_cyc(1);
        btn_step = 1'b0;
        chk("ab_valid", mv_valid, 1);
        chk("ab_idx", mv_idx, 0);
        comp = 1'b0;
        wait_cyc(1);
        chk("ab_outs", {mv_valid, num, playing, done}, 0);
        cnt = 6'd0; comp = 1'b1;
        wait_cyc(2);
        chk("empty_done", done, 1);
        chk("empty_valid", mv_valid, 0);

        // Asynchronous reset mid-WAIT
        comp = 1'b0;
        wait_cyc(1);
        cnt = 6'd5; comp = 1'b1; mv_ready = 1'b1;
        wait_cyc(2);
        btn_play = 1'b1;
        wait_cyc(6);
        chk("ar_playing_before", playing, 1);
        #2 rst_n = 1'b0;
        #1 chk("ar_outs", outs, 0);
        btn_play = 1'b0;
        comp = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        press(3'b010);
        chk("ar_play_no_comp", playing, 0);
        chk("ar_outs_idle", outs, 0);
        comp = 1'b1;
        wait_cyc(4);
        chk("ar_comp_playing", playing, 0);
        chk("ar_comp_valid", mv_valid, 0);
        press(3'b010);
        chk("ar_play_works", playing, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
